// File: rtl/pipeline_pkg.sv
// Shared pipeline types: interrupt sequencer state encoding, flag bit positions, vector default.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package pipeline_pkg;

  typedef enum logic [3:0] {
    IDLE,
    DRAIN,
    PUSH_HI,
    PUSH_LO,
    PUSH_FLG,
    VEC_RD,
    VEC_WAIT,
    POP_FLG,
    POP_LO,
    POP_HI,
    POP_WAIT
  } seq_state_t;

  // Flag register layout is {C, N, Z}.
  localparam int FLAG_C = 2;
  localparam int FLAG_N = 1;
  localparam int FLAG_Z = 0;

  localparam logic [31:0] DEFAULT_VECTOR_ADDR = 32'd0;

  // Stack word holding the flags, zero-extended into a 16-bit memory word.
  function automatic logic [15:0] flags_word(input logic [2:0] f);
    return {13'b0, f[FLAG_C], f[FLAG_N], f[FLAG_Z]};
  endfunction

endpackage

// File: rtl/edge_pending_latch.sv
// Rising-edge detector on int_req feeding a set/clear pending flop.
// Latency: pending rises the cycle after the int_req edge; clear takes effect next cycle.
// Backpressure: none; a pending request is held until the sequencer consumes it, a new edge wins over clear.
module edge_pending_latch (
  input  logic clk,
  input  logic reset,
  input  logic int_req,
  input  logic clear,
  output logic pending
);

  logic int_req_d;
  logic int_rise;

  assign int_rise = int_req & ~int_req_d;

  // Remember the previous request level and hold pending until consumed.
  always_ff @(posedge clk) begin
    if (reset) begin
      int_req_d <= 1'b0;
      pending   <= 1'b0;
    end else begin
      int_req_d <= int_req;
      if (int_rise)
        pending <= 1'b1;
      else if (clear)
        pending <= 1'b0;
    end
  end

endmodule

// File: rtl/interrupt_sequencer.sv
// Sequences interrupt entry (drain, push PC/flags, load vector) and RTI return (pop flags/PC). Option: INTERRUPT_NESTING_EN.
// Latency: entry pc_load 6 cycles after IDLE sees pending (+1 per busy DRAIN cycle); return pc_load 4 cycles after rti_req.
// Backpressure: DRAIN waits while pipe_mem_busy; stall/flush are held for the whole sequence.
module interrupt_sequencer
  import pipeline_pkg::*;
#(
  parameter logic [31:0] VECTOR_ADDR = DEFAULT_VECTOR_ADDR
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        int_req,
  input  logic        rti_req,
  input  logic        pipe_mem_busy,
  input  logic [31:0] pc_next,
  input  logic [2:0]  flags,
  input  logic [15:0] mem_rdata,
  output logic        stall,
  output logic        flush,
  output logic        seq_push,
  output logic [15:0] seq_wdata,
  output logic        seq_pop,
  output logic        seq_read_vec,
  output logic        pc_load,
  output logic [31:0] pc_load_value,
  output logic        flags_restore_en,
  output logic [2:0]  flags_restore,
  output logic        in_handler,
  output logic        busy
);

  // The handler vector is a 16-bit word; the memory side decodes a 16-bit data address.
  if (VECTOR_ADDR[31:16] != 16'd0) begin : g_vector_addr_range
    $error("VECTOR_ADDR must fit a 16-bit data address");
  end

  seq_state_t  state;
  seq_state_t  next_state;
  logic [31:0] ret_pc;
  logic [15:0] pc_lo;
  logic        hold_q;
  logic        pending;
  logic        pend_clear;
  logic        entry_ok;

  edge_pending_latch u_pending (
    .clk     (clk),
    .reset   (reset),
    .int_req (int_req),
    .clear   (pend_clear),
    .pending (pending)
  );

  assign stall = hold_q;
  assign flush = hold_q;
  assign busy  = (state != IDLE);

`ifdef INTERRUPT_NESTING_EN
  logic [3:0] depth;

  assign entry_ok   = 1'b1;
  assign in_handler = (depth != 4'd0);

  // Nesting depth: entries count up, returns count down, saturating at both ends.
  always_ff @(posedge clk) begin
    if (reset)
      depth <= 4'd0;
    else if (state == VEC_WAIT && depth != 4'd15)
      depth <= depth + 4'd1;
    else if (state == POP_WAIT && depth != 4'd0)
      depth <= depth - 4'd1;
  end
`else
  assign entry_ok = ~in_handler;

  // Handler flag: set when the vector is loaded, cleared when the return PC is loaded.
  always_ff @(posedge clk) begin
    if (reset)
      in_handler <= 1'b0;
    else if (state == VEC_WAIT)
      in_handler <= 1'b1;
    else if (state == POP_WAIT)
      in_handler <= 1'b0;
  end
`endif

  // State register plus return-PC capture; stall/flush register follows the next state.
  always_ff @(posedge clk) begin
    if (reset) begin
      state  <= IDLE;
      ret_pc <= 32'd0;
      pc_lo  <= 16'd0;
      hold_q <= 1'b0;
    end else begin
      state  <= next_state;
      hold_q <= (next_state != IDLE);
      if (pend_clear)
        ret_pc <= pc_next;
      if (state == POP_HI)
        pc_lo <= mem_rdata;
    end
  end

  // Next-state and per-state datapath controls; RTI has priority over a pending entry.
  always_comb begin
    next_state       = state;
    pend_clear       = 1'b0;
    seq_push         = 1'b0;
    seq_wdata        = 16'd0;
    seq_pop          = 1'b0;
    seq_read_vec     = 1'b0;
    pc_load          = 1'b0;
    pc_load_value    = 32'd0;
    flags_restore_en = 1'b0;
    flags_restore    = 3'b000;
    case (state)
      IDLE: begin
        if (rti_req) begin
          next_state = POP_FLG;
        end else if (pending && entry_ok) begin
          next_state = DRAIN;
          pend_clear = 1'b1;
        end
      end
      DRAIN: begin
        if (!pipe_mem_busy)
          next_state = PUSH_HI;
      end
      PUSH_HI: begin
        seq_push   = 1'b1;
        seq_wdata  = ret_pc[31:16];
        next_state = PUSH_LO;
      end
      PUSH_LO: begin
        seq_push   = 1'b1;
        seq_wdata  = ret_pc[15:0];
        next_state = PUSH_FLG;
      end
      PUSH_FLG: begin
        seq_push   = 1'b1;
        seq_wdata  = flags_word(flags);
        next_state = VEC_RD;
      end
      VEC_RD: begin
        seq_read_vec = 1'b1;
        next_state   = VEC_WAIT;
      end
      VEC_WAIT: begin
        pc_load       = 1'b1;
        pc_load_value = {16'd0, mem_rdata};
        next_state    = IDLE;
      end
      POP_FLG: begin
        seq_pop    = 1'b1;
        next_state = POP_LO;
      end
      POP_LO: begin
        seq_pop          = 1'b1;
        flags_restore_en = 1'b1;
        flags_restore    = {mem_rdata[FLAG_C], mem_rdata[FLAG_N], mem_rdata[FLAG_Z]};
        next_state       = POP_HI;
      end
      POP_HI: begin
        seq_pop    = 1'b1;
        next_state = POP_WAIT;
      end
      POP_WAIT: begin
        pc_load       = 1'b1;
        pc_load_value = {mem_rdata, pc_lo};
        next_state    = IDLE;
      end
      default: next_state = IDLE;
    endcase
  end

endmodule

// File: tb/tb_interrupt_sequencer.sv
// Bench for interrupt_sequencer: stack/vector memory model, event scoreboard, table-driven entry/return rows.
// Latency: checks entry, return and flags-restore cycle offsets against fixed expectations.
// Backpressure: drives pipe_mem_busy during DRAIN and checks pushes wait for it.
module tb_interrupt_sequencer;

  logic        clk = 1'b0;
  logic        reset;
  logic        int_req;
  logic        rti_req;
  logic        pipe_mem_busy;
  logic [31:0] pc_next;
  logic [2:0]  flags;
  logic [15:0] mem_rdata;
  logic        stall, flush, seq_push, seq_pop, seq_read_vec, pc_load;
  logic        flags_restore_en, in_handler, busy;
  logic [15:0] seq_wdata;
  logic [31:0] pc_load_value;
  logic [2:0]  flags_restore;
  logic [15:0] vec_word;

  interrupt_sequencer dut (
    .clk              (clk),
    .reset            (reset),
    .int_req          (int_req),
    .rti_req          (rti_req),
    .pipe_mem_busy    (pipe_mem_busy),
    .pc_next          (pc_next),
    .flags            (flags),
    .mem_rdata        (mem_rdata),
    .stall            (stall),
    .flush            (flush),
    .seq_push         (seq_push),
    .seq_wdata        (seq_wdata),
    .seq_pop          (seq_pop),
    .seq_read_vec     (seq_read_vec),
    .pc_load          (pc_load),
    .pc_load_value    (pc_load_value),
    .flags_restore_en (flags_restore_en),
    .flags_restore    (flags_restore),
    .in_handler       (in_handler),
    .busy             (busy)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int passed = 0;
  int cyc = 0;

  localparam int EV_PUSH = 0;
  localparam int EV_FLG  = 1;
  localparam int EV_PCL  = 2;

  typedef struct {
    int          kind;
    logic [31:0] val;
  } ev_t;

  typedef struct {
    logic [31:0] pc;
    logic [2:0]  flg;
    logic [15:0] vec;
    int          nb;
    int          exp_lat;
    logic [15:0] exp_hi;
    logic [15:0] exp_lo;
    logic [15:0] exp_fw;
    logic [31:0] exp_pcl;
  } row_t;

  ev_t         sbq[$];
  logic [15:0] stk[$];
  int          push_cyc_q[$];
  int          flg_cyc_q[$];
  int          pcl_cyc_q[$];
  row_t        rows[4];

  always @(posedge clk) cyc++;

  // Stack and vector memory: read data appears the cycle after pop/read_vec.
  always @(posedge clk) begin
    if (reset) begin
      stk.delete();
      mem_rdata <= 16'h0;
    end else begin
      if (seq_push)
        stk.push_back(seq_wdata);
      if (seq_pop) begin
        if (stk.size() > 0)
          mem_rdata <= stk.pop_back();
        else
          mem_rdata <= 16'h0;
      end else if (seq_read_vec) begin
        mem_rdata <= vec_word;
      end
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act === exp)
      passed++;
    else
      $display("FAIL %s: got %h, expected %h", name, act, exp);
  endtask

  task automatic expect_ev(input int k, input logic [31:0] v);
    ev_t e;
    e.kind = k;
    e.val  = v;
    sbq.push_back(e);
  endtask

  task automatic sb_match(input int k, input logic [31:0] v, input string name);
    ev_t e;
    if (sbq.size() == 0) begin
      checks++;
      $display("FAIL %s_unexpected: got %h with nothing expected", name, v);
    end else begin
      e = sbq.pop_front();
      chk({name, "_kind"}, 32'(k), 32'(e.kind));
      chk(name, v, e.val);
    end
  endtask

  // Observe DUT events mid-cycle and match them against the scoreboard.
  always @(negedge clk) begin
    if (busy === 1'b1)
      chk("mem_ops_exclusive", 32'((32'(seq_push) + 32'(seq_pop) + 32'(seq_read_vec)) > 1), 32'd0);
    if (seq_push === 1'b1) begin
      push_cyc_q.push_back(cyc);
      sb_match(EV_PUSH, {16'h0, seq_wdata}, "push");
    end
    if (flags_restore_en === 1'b1) begin
      flg_cyc_q.push_back(cyc);
      sb_match(EV_FLG, {29'h0, flags_restore}, "flags_restore");
    end
    if (pc_load === 1'b1) begin
      pcl_cyc_q.push_back(cyc);
      sb_match(EV_PCL, pc_load_value, "pc_load");
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic pulse_int();
    int_req = 1'b1;
    step();
    int_req = 1'b0;
  endtask

  task automatic wait_pcl(input int target, input int budget, input string name);
    int n;
    n = 0;
    while (pcl_cyc_q.size() < target && n < budget) begin
      step();
      n++;
    end
    if (pcl_cyc_q.size() < target) begin
      checks++;
      $display("FAIL %s_timeout: got %0d pc_load pulses, expected %0d", name, pcl_cyc_q.size(), target);
    end
  endtask

  task automatic check_idle_outputs(input string tag);
    chk({tag, "_stall"}, 32'(stall), 32'd0);
    chk({tag, "_flush"}, 32'(flush), 32'd0);
    chk({tag, "_seq_push"}, 32'(seq_push), 32'd0);
    chk({tag, "_seq_wdata"}, 32'(seq_wdata), 32'd0);
    chk({tag, "_seq_pop"}, 32'(seq_pop), 32'd0);
    chk({tag, "_seq_read_vec"}, 32'(seq_read_vec), 32'd0);
    chk({tag, "_pc_load"}, 32'(pc_load), 32'd0);
    chk({tag, "_pc_load_value"}, pc_load_value, 32'd0);
    chk({tag, "_flags_restore_en"}, 32'(flags_restore_en), 32'd0);
    chk({tag, "_flags_restore"}, 32'(flags_restore), 32'd0);
    chk({tag, "_in_handler"}, 32'(in_handler), 32'd0);
    chk({tag, "_busy"}, 32'(busy), 32'd0);
  endtask

  // One interrupt entry from IDLE; busy is held for r.nb cycles of DRAIN.
  task automatic run_entry(input row_t r);
    int c0, n, pb, lb;
    pc_next  = r.pc;
    flags    = r.flg;
    vec_word = r.vec;
    expect_ev(EV_PUSH, {16'h0, r.exp_hi});
    expect_ev(EV_PUSH, {16'h0, r.exp_lo});
    expect_ev(EV_PUSH, {16'h0, r.exp_fw});
    expect_ev(EV_PCL, r.exp_pcl);
    pb = push_cyc_q.size();
    lb = pcl_cyc_q.size();
    pulse_int();
    c0 = cyc;
    n = 0;
    while (pcl_cyc_q.size() == lb && n < 40) begin
      pipe_mem_busy = (n >= 1 && n <= r.nb);
      if (n == 1) begin
        chk("stall_in_drain", 32'(stall), 32'd1);
        chk("flush_in_drain", 32'(flush), 32'd1);
      end
      step();
      n++;
    end
    pipe_mem_busy = 1'b0;
    if (pcl_cyc_q.size() > lb && push_cyc_q.size() > pb) begin
      chk("entry_latency", 32'(pcl_cyc_q[lb] - c0), 32'(r.exp_lat));
      chk("first_push_cycle", 32'(push_cyc_q[pb] - c0), 32'(r.nb + 2));
    end else begin
      checks++;
      $display("FAIL entry_timeout: got no pc_load within 40 cycles, expected one at %0d", r.exp_lat);
    end
    chk("in_handler_after_entry", 32'(in_handler), 32'd1);
    chk("busy_after_entry", 32'(busy), 32'd0);
  endtask

  task automatic run_rti(input logic [31:0] exp_pc, input logic [2:0] exp_flg, input logic exp_ih);
    int r0, lb, fb;
    expect_ev(EV_FLG, {29'h0, exp_flg});
    expect_ev(EV_PCL, exp_pc);
    lb = pcl_cyc_q.size();
    fb = flg_cyc_q.size();
    r0 = cyc;
    rti_req = 1'b1;
    step();
    rti_req = 1'b0;
    wait_pcl(lb + 1, 20, "rti");
    if (pcl_cyc_q.size() > lb && flg_cyc_q.size() > fb) begin
      chk("rti_latency", 32'(pcl_cyc_q[lb] - r0), 32'd4);
      chk("flags_restore_cycle", 32'(flg_cyc_q[fb] - r0), 32'd2);
    end
    chk("in_handler_after_rti", 32'(in_handler), 32'(exp_ih));
  endtask

  initial begin
    int   r0, lb, pb;
    row_t ra, rb;

    reset = 1'b1; int_req = 1'b0; rti_req = 1'b0; pipe_mem_busy = 1'b0;
    pc_next = 32'h0; flags = 3'b000; vec_word = 16'h0;

    //           pc            flg     vec      nb lat hi       lo       fw       pc_load
    rows[0] = '{32'h0000_1234, 3'b101, 16'h0040, 0, 6, 16'h0000, 16'h1234, 16'h0005, 32'h0000_0040};
    rows[1] = '{32'hDEAD_BEEF, 3'b010, 16'h8000, 3, 9, 16'hDEAD, 16'hBEEF, 16'h0002, 32'h0000_8000};
    rows[2] = '{32'hFFFF_FFFE, 3'b111, 16'hFFFF, 1, 7, 16'hFFFF, 16'hFFFE, 16'h0007, 32'h0000_FFFF};
    rows[3] = '{32'h0000_0000, 3'b000, 16'h0001, 0, 6, 16'h0000, 16'h0000, 16'h0000, 32'h0000_0001};

    repeat (3) step();
    check_idle_outputs("reset");
    reset = 1'b0;
    step();

    // Entry followed by return for each table row.
    for (int i = 0; i < 4; i++) begin
      run_entry(rows[i]);
      run_rti(rows[i].pc, rows[i].flg, 1'b0);
      step();
    end

    // RTI and a pending interrupt in the same IDLE cycle: return first, then entry.
    ra = '{32'h0000_2000, 3'b011, 16'h0100, 0, 6, 16'h0000, 16'h2000, 16'h0003, 32'h0000_0100};
    run_entry(ra);
    pc_next = 32'h0000_3000; flags = 3'b100; vec_word = 16'h0200;
    expect_ev(EV_FLG, 32'h3);
    expect_ev(EV_PCL, 32'h0000_2000);
    expect_ev(EV_PUSH, 32'h0000);
    expect_ev(EV_PUSH, 32'h3000);
    expect_ev(EV_PUSH, 32'h0004);
    expect_ev(EV_PCL, 32'h0000_0200);
    lb = pcl_cyc_q.size();
    int_req = 1'b1;
    step();
    rti_req = 1'b1;
    r0 = cyc;
    step();
    rti_req = 1'b0;
    int_req = 1'b0;
    wait_pcl(lb + 2, 40, "rti_then_entry");
    if (pcl_cyc_q.size() >= lb + 2) begin
      chk("prio_rti_latency", 32'(pcl_cyc_q[lb] - r0), 32'd4);
      chk("prio_entry_latency", 32'(pcl_cyc_q[lb + 1] - r0), 32'd11);
    end
    run_rti(32'h0000_3000, 3'b100, 1'b0);
    step();

    // Second interrupt while inside a handler.
    ra = '{32'h0000_5000, 3'b001, 16'h0300, 0, 6, 16'h0000, 16'h5000, 16'h0001, 32'h0000_0300};
    rb = '{32'h0000_6000, 3'b110, 16'h0400, 0, 6, 16'h0000, 16'h6000, 16'h0006, 32'h0000_0400};
    run_entry(ra);
`ifdef INTERRUPT_NESTING_EN
    run_entry(rb);
    run_rti(32'h0000_6000, 3'b110, 1'b1);
    run_rti(32'h0000_5000, 3'b001, 1'b0);
`else
    pc_next = rb.pc; flags = rb.flg; vec_word = rb.vec;
    expect_ev(EV_FLG, 32'h1);
    expect_ev(EV_PCL, 32'h0000_5000);
    expect_ev(EV_PUSH, 32'h0000);
    expect_ev(EV_PUSH, 32'h6000);
    expect_ev(EV_PUSH, 32'h0006);
    expect_ev(EV_PCL, 32'h0000_0400);
    lb = pcl_cyc_q.size();
    pb = push_cyc_q.size();
    pulse_int();
    repeat (10) step();
    chk("no_entry_in_handler", 32'(push_cyc_q.size() - pb), 32'd0);
    chk("idle_in_handler", 32'(busy), 32'd0);
    r0 = cyc;
    rti_req = 1'b1;
    step();
    rti_req = 1'b0;
    wait_pcl(lb + 2, 40, "deferred_entry");
    if (pcl_cyc_q.size() >= lb + 2) begin
      chk("deferred_rti_latency", 32'(pcl_cyc_q[lb] - r0), 32'd4);
      chk("deferred_entry_latency", 32'(pcl_cyc_q[lb + 1] - r0), 32'd11);
    end
    run_rti(32'h0000_6000, 3'b110, 1'b0);
`endif
    step();

    // Reset during PUSH_LO: back to IDLE, nothing further happens.
    pc_next = 32'h0000_7777; flags = 3'b010; vec_word = 16'h0500;
    expect_ev(EV_PUSH, 32'h0000);
    expect_ev(EV_PUSH, 32'h7777);
    lb = pcl_cyc_q.size();
    pulse_int();
    repeat (3) step();
    reset = 1'b1;
    step();
    reset = 1'b0;
    check_idle_outputs("mid_reset");
    repeat (10) step();
    chk("no_load_after_reset", 32'(pcl_cyc_q.size() - lb), 32'd0);
    chk("idle_after_reset", 32'(busy), 32'd0);

    // RTI outside a handler pops the (empty) stack as-is.
    run_rti(32'h0000_0000, 3'b000, 1'b0);
    step();

    // Normal entry/return still work after the mid-sequence reset.
    run_entry(rows[0]);
    run_rti(rows[0].pc, rows[0].flg, 1'b0);
    step();

    chk("scoreboard_drained", 32'(sbq.size()), 32'd0);
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
